// File: rtl/if_prefetch_pkg.sv
// Shared core constants and types for the instruction-fetch prefetcher.
// Holds the reset fetch address, the default buffer depth and the buffer entry layout.
package if_prefetch_pkg;

    localparam logic [31:0] PF_RESET_PC = 32'h0000_0000;
    localparam int          PF_DEPTH    = 4;

    // One buffered fetch: instruction word plus the address it was fetched from.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
    } pf_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// Instruction buffer for the prefetcher: DEPTH x 64-bit circular FIFO.
// Supports push, pop and flush, and exposes its occupancy count.
module prefetch_fifo
    import if_prefetch_pkg::*;
#(
    parameter int DEPTH = PF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  pf_entry_t                push_entry,
    input  logic                     pop,
    output pf_entry_t                head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int              AW   = $clog2(DEPTH);
    localparam int              CW   = AW + 1;
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);

    pf_entry_t     mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    // NOTE: the storage array is reset on purpose: the head entry drives the
    // module outputs directly and has to read as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

    a_no_pop_when_empty : assert property (
        @(posedge clk) disable iff (!rst_n) !(pop && !flush && count == '0));

    a_no_push_when_full : assert property (
        @(posedge clk) disable iff (!rst_n) !(push && !flush && count == FULL));

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetcher: issues sequential word fetches, buffers the responses and
// presents them in order to the IF stage; a redirect flushes and refetches.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PF_RESET_PC,
    parameter int          DEPTH    = PF_DEPTH
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    output logic        o_mem_req,
    output logic [31:0] o_mem_instrAddr,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_instr,
    output logic        o_valid,
    output logic [31:0] o_instruction,
    output logic [31:0] o_instrAddr,
    input  logic        i_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirectAddr
);

    localparam int            CW        = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_LIM = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_addr;
    logic          inflight;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic          grant;
    logic          push;
    logic          pop;
    pf_entry_t     head;
    pf_entry_t     push_entry;

    // The outstanding fetch reserves a slot, so a full buffer can never be overrun.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign o_mem_req = i_reset_n && !i_redirect && (occupancy < DEPTH_LIM);
    assign grant     = o_mem_req && i_mem_gnt;

    assign push       = i_mem_rvalid && inflight && !i_redirect;
    assign pop        = o_valid && i_ready && !i_redirect;
    assign push_entry = '{instr: i_mem_instr, addr: inflight_addr};

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            fetch_pc      <= word_align(RESET_PC);
            inflight      <= 1'b0;
            inflight_addr <= '0;
        end else if (i_redirect) begin
            fetch_pc <= word_align(i_redirectAddr);
            inflight <= 1'b0;
        end else begin
            inflight <= grant;
            if (grant) begin
                fetch_pc      <= fetch_pc + 32'd4;
                inflight_addr <= fetch_pc;
            end
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (i_clk),
        .rst_n      (i_reset_n),
        .flush      (i_redirect),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count)
    );

    assign o_mem_instrAddr = fetch_pc;
    assign o_valid         = (count != '0);
    assign o_instruction   = head.instr;
    assign o_instrAddr     = head.addr;

endmodule

// File: tb/tb_if_prefetch.sv
// Scoreboard bench for if_prefetch: directed scenarios plus randomized traffic,
// checked against an address-stream model of sequential fetch with flush on redirect.
`timescale 1ns/1ps
module tb_if_prefetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        o_mem_req;
    logic [31:0] o_mem_instrAddr;
    logic        i_mem_gnt = 1'b0;
    logic        i_mem_rvalid = 1'b0;
    logic [31:0] i_mem_instr = '0;
    logic        o_valid;
    logic [31:0] o_instruction;
    logic [31:0] o_instrAddr;
    logic        i_ready = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirectAddr = '0;

    if_prefetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .i_clk           (i_clk),
        .i_reset_n       (i_reset_n),
        .o_mem_req       (o_mem_req),
        .o_mem_instrAddr (o_mem_instrAddr),
        .i_mem_gnt       (i_mem_gnt),
        .i_mem_rvalid    (i_mem_rvalid),
        .i_mem_instr     (i_mem_instr),
        .o_valid         (o_valid),
        .o_instruction   (o_instruction),
        .o_instrAddr     (o_instrAddr),
        .i_ready         (i_ready),
        .i_redirect      (i_redirect),
        .i_redirectAddr  (i_redirectAddr)
    );

    always #5 i_clk = ~i_clk;

    // Expected instruction stream: every accepted request yields one entry, in order.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        int          t;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_pc = RESET_PC;
    logic        exp_req_now = 1'b0;
    int          ncyc = 0;
    int          n_vec = 0;
    int          n_fail = 0;
    int          n_pops = 0;
    int          n_grants = 0;
    logic        resp_pending = 1'b0;
    logic [31:0] resp_data = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'd1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares visible outputs with the model, pops on consumption.
    always @(negedge i_clk) begin : monitor
        logic exp_valid;
        ncyc++;
        if (!i_reset_n) begin
            exp_req_now = 1'b0;
            check("reset o_mem_req", 32'(o_mem_req), 32'd0);
            check("reset o_valid", 32'(o_valid), 32'd0);
            check("reset o_instruction", o_instruction, 32'd0);
            check("reset o_instrAddr", o_instrAddr, 32'd0);
        end else begin
            exp_valid   = (exp_q.size() > 0) && (exp_q[0].t <= ncyc - 2);
            exp_req_now = !i_redirect && (exp_q.size() < DEPTH);
            check("o_valid", 32'(o_valid), 32'(exp_valid));
            check("o_mem_req", 32'(o_mem_req), 32'(exp_req_now));
            if (exp_req_now) begin
                check("o_mem_instrAddr", o_mem_instrAddr, model_pc);
            end
            if (exp_valid) begin
                check("o_instruction", o_instruction, exp_q[0].instr);
                check("o_instrAddr", o_instrAddr, exp_q[0].addr);
                if (i_ready && !i_redirect) begin
                    void'(exp_q.pop_front());
                    n_pops++;
                end
            end
        end
    end

    // Scoreboard feed and memory responder: runs just after the monitor each cycle.
    always @(negedge i_clk) begin : feeder
        #1;
        if (!i_reset_n) begin
            exp_q.delete();
            model_pc = RESET_PC;
        end else if (i_redirect) begin
            exp_q.delete();
            model_pc = {i_redirectAddr[31:2], 2'b00};
        end else if (exp_req_now && i_mem_gnt) begin
            exp_q.push_back('{addr: model_pc, instr: mem_word(model_pc), t: ncyc});
            model_pc = model_pc + 32'd4;
        end
        if (i_reset_n && o_mem_req && i_mem_gnt) begin
            resp_pending = 1'b1;
            resp_data    = mem_word(o_mem_instrAddr);
            n_grants++;
        end
    end

    task automatic tick(input logic gnt, input logic rdy, input logic redir = 1'b0,
                        input logic [31:0] raddr = 32'd0, input logic spur = 1'b0);
        @(posedge i_clk);
        #1;
        i_mem_gnt      = gnt;
        i_ready        = rdy;
        i_redirect     = redir;
        i_redirectAddr = raddr;
        if (resp_pending) begin
            i_mem_rvalid = 1'b1;
            i_mem_instr  = resp_data;
        end else begin
            i_mem_rvalid = spur;
            i_mem_instr  = $urandom;
        end
        resp_pending = 1'b0;
    endtask

    task automatic settle();
        @(negedge i_clk);
        #2;
    endtask

    initial begin
        logic [31:0] held_pc;

        // Reset, then continuous grant and ready from RESET_PC.
        repeat (3) tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        i_reset_n = 1'b1;
        repeat (9) tick(1'b1, 1'b1);
        settle();
        n_pops = 0;
        repeat (10) tick(1'b1, 1'b1);
        settle();
        check("throughput pops in 10 cycles", n_pops, 32'd10);

        // Stalled consumer: buffer fills to DEPTH, then one pop frees exactly one request.
        tick(1'b1, 1'b0, 1'b1, 32'h0000_0200);
        settle();
        n_grants = 0;
        repeat (8) tick(1'b1, 1'b0);
        settle();
        check("grants while stalled", n_grants, 32'd4);
        check("req low when full", 32'(o_mem_req), 32'd0);
        n_grants = 0;
        tick(1'b1, 1'b1);
        repeat (4) tick(1'b1, 1'b0);
        settle();
        check("grants after one pop", n_grants, 32'd1);

        // Redirect with three entries buffered and a response arriving.
        tick(1'b1, 1'b0, 1'b1, 32'h0000_0300);
        repeat (4) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0102);
        tick(1'b1, 1'b1);
        settle();
        check("valid after redirect", 32'(o_valid), 32'd0);
        check("first addr after redirect", o_mem_instrAddr, 32'h0000_0100);
        repeat (2) tick(1'b1, 1'b1);
        settle();
        check("first head after redirect", o_instrAddr, 32'h0000_0100);

        // Grant held low: request address must hold, then advance by exactly one word.
        tick(1'b0, 1'b1);
        settle();
        held_pc = model_pc;
        repeat (4) begin
            tick(1'b0, 1'b1);
            settle();
            check("addr stable without grant", o_mem_instrAddr, held_pc);
        end
        tick(1'b1, 1'b1);
        settle();
        check("addr at grant", o_mem_instrAddr, held_pc);
        tick(1'b1, 1'b1);
        settle();
        check("addr after grant", o_mem_instrAddr, held_pc + 32'd4);

        // Address wrap at the top of the space.
        tick(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        tick(1'b1, 1'b1);
        settle();
        check("addr at top", o_mem_instrAddr, 32'hFFFF_FFFC);
        tick(1'b1, 1'b1);
        settle();
        check("addr wraps", o_mem_instrAddr, 32'h0000_0000);
        repeat (6) tick(1'b1, 1'b1);

        // Reset pulse mid-stream, stray rvalid right after release.
        tick(1'b1, 1'b1);
        i_reset_n = 1'b0;
        repeat (2) tick(1'b1, 1'b1);
        settle();
        check("mid reset o_valid", 32'(o_valid), 32'd0);
        tick(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        i_reset_n = 1'b1;
        settle();
        check("restart addr", o_mem_instrAddr, RESET_PC);
        tick(1'b1, 1'b1);
        settle();
        check("stray rvalid ignored", 32'(o_valid), 32'd0);
        tick(1'b1, 1'b1);
        settle();
        check("stray rvalid ignored 2", 32'(o_valid), 32'd0);
        tick(1'b1, 1'b1);
        settle();
        check("restart head addr", o_instrAddr, RESET_PC);

        // Randomized traffic.
        repeat (400) begin
            tick($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 7) == 0);
        end
        repeat (5) tick(1'b1, 1'b1);
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address after reset.
REQ-002 Parameter DEPTH, default 4: instruction buffer entries; power of two, at least 2.
REQ-003 i_clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 i_reset_n  in  1  reset, asynchronous, active-low.
REQ-005 o_mem_req  out  1  instruction-memory fetch request.
REQ-006 o_mem_instrAddr  out  32  fetch address, word-aligned.
REQ-007 i_mem_gnt  in  1  memory accepts the request this cycle.
REQ-008 i_mem_rvalid  in  1  fetch data valid; asserted exactly one cycle after a grant.
REQ-009 i_mem_instr  in  32  fetch data.
REQ-010 o_valid  out  1  buffer head holds a valid instruction.
REQ-011 o_instruction  out  32  head instruction.
REQ-012 o_instrAddr  out  32  address of the head instruction.
REQ-013 i_ready  in  1  IF stage consumes the head this cycle.
REQ-014 i_redirect  in  1  branch/jump taken; flush the buffer and refetch.
REQ-015 i_redirectAddr  in  32  new fetch address; bits [1:0] ignored.

Function
REQ-016 A request is accepted on a cycle where o_mem_req and i_mem_gnt are both high; on acceptance the fetch PC advances by 4 (mod 2^32, wraps 0xFFFF_FFFC->0) and inflight is set for one cycle.
REQ-017 o_mem_req = !i_redirect && (count + inflight < DEPTH); a pop in the same cycle is not credited, so the buffer never overflows.
REQ-018 On i_mem_rvalid with inflight set and no redirect, the buffer shall write {data, address of the granted request} at the tail.
REQ-019 A pop occurs when o_valid && i_ready; o_valid = (count != 0); o_instruction and o_instrAddr come straight from the head registers with no combinational path from inputs.
REQ-020 A simultaneous push and pop leaves count unchanged; a pop when empty and a push when full are impossible by construction; an assertion checks both.
REQ-021 On i_redirect: count becomes 0, any rvalid in that cycle is dropped, fetch PC becomes {i_redirectAddr[31:2],2'b00}, and i_ready is ignored.
REQ-022 Redirect latency: redirect sampled at edge N; request at the new address during cycle N+1; with immediate grant, o_valid is high after edge N+2.
REQ-023 Back-to-back redirects: the last one wins; each one repeats REQ-021.
REQ-024 An i_mem_rvalid without inflight set shall be ignored.
REQ-025 Steady-state throughput with continuous grant and i_ready is one instruction per cycle.

Reset
REQ-026 Asynchronous assertion: count=0, inflight=0, fetch PC=RESET_PC, head/tail pointers=0, o_valid=0, o_instruction=0, o_instrAddr=0.
REQ-027 o_mem_req is low while i_reset_n is low; it may rise in the first cycle after deassertion with o_mem_instrAddr=RESET_PC.
REQ-028 Reset mid-operation discards all buffered and in-flight data, and any later rvalid is ignored per REQ-024.

Structure
REQ-029 RESET_PC default and PF_DEPTH constants shall be defined in the shared core package; the module parameters default to them.
REQ-030 The buffer shall be the sub-module prefetch_fifo (DEPTH x 64 bits, push/pop/flush, count output); fetch PC and inflight logic stay in if_prefetch.

Verification
REQ-031 Reset release, gnt=1, ready=1, memory[n]=n*4+1 -> addresses 0,4,8,... issued; o_valid rises two edges after the first grant; instructions 1,5,9 appear in order at one per cycle.
REQ-032 ready=0 with continuous grant -> exactly 4 requests issued, o_mem_req then low, count=4; one pop -> exactly one new request.
REQ-033 Redirect to 0x0000_0102 while 3 entries are buffered and a response is arriving -> response dropped, o_valid low the next cycle, next request address 0x0000_0100, first output o_instrAddr=0x100.
REQ-034 gnt held low for 5 cycles, then high -> o_mem_instrAddr stable at the same value throughout, no duplicate or skipped address.
REQ-035 Fetch PC at 0xFFFF_FFFC granted -> next request address 0x0000_0000.
REQ-036 i_reset_n pulsed low mid-stream, with one rvalid arriving after release -> outputs zero, that rvalid ignored, fetching restarts at RESET_PC.
